// File: rtl/led_pkg.sv
// ============================================================================
//  led_pkg : shared types and constants for the LED arbiter
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package led_pkg;

    // Per-requester LED drive request
    typedef enum logic [1:0] {
        STATE_OFF   = 2'd0,
        STATE_BLINK = 2'd1,
        STATE_ON    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    // 10 Hz tick from a 50 MHz clock
    localparam int c_DEFAULT_TICK_DIVIDER = 5_000_000;

endpackage

`default_nettype wire

// File: rtl/tick_counter.sv
// ============================================================================
//  tick_counter : free-running divider, single-cycle tick every TICK_DIVIDER
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_counter
    import led_pkg::*;
#(
    parameter int TICK_DIVIDER = c_DEFAULT_TICK_DIVIDER
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              c_W    = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(TICK_DIVIDER - 1);

    logic [c_W-1:0] count_q;
    logic [c_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == c_LAST) ? '0 : count_q + c_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable & (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/led_arbiter.sv
// ============================================================================
//  led_arbiter : round-robin time-sliced sharing of one LED between requesters
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_arbiter
    import led_pkg::*;
#(
    parameter int REQ_COUNT    = 4,
    parameter int SLOT_TICKS   = 10,
    parameter int TICK_DIVIDER = c_DEFAULT_TICK_DIVIDER
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REQ_COUNT-1:0]   req,
    input  logic [2*REQ_COUNT-1:0] mode,
    output logic [REQ_COUNT-1:0]   grant,
    output logic                   busy,
    output logic                   led
);

    localparam int                   c_IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int                   c_SLOT_W    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [c_IDX_W:0]     c_REQ_N     = (c_IDX_W + 1)'(REQ_COUNT);
    localparam logic [c_SLOT_W-1:0]  c_SLOT_LAST = c_SLOT_W'(SLOT_TICKS - 1);

    arb_state_t            state_q, state_d;
    logic [REQ_COUNT-1:0]  grant_q, grant_d;
    logic                  busy_q,  busy_d;
    logic                  led_q,   led_d;
    logic [c_IDX_W-1:0]    idx_q,   idx_d;
    logic [c_IDX_W-1:0]    ptr_q,   ptr_d;
    logic [c_SLOT_W-1:0]   slot_q,  slot_d;
    logic                  phase_q, phase_d;

    logic                  tick;
    logic [c_IDX_W-1:0]    pick;
    logic [c_IDX_W:0]      cand;
    logic [c_IDX_W:0]      ptr_sum;
    logic [c_IDX_W-1:0]    ptr_next;
    state_t                cur_mode;

    tick_counter #(
        .TICK_DIVIDER (TICK_DIVIDER)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == ARB_GRANT),
        .clear  (state_q != ARB_GRANT),
        .tick   (tick)
    );

    // Scan offsets high to low so the nearest requester after ptr wins last
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (c_IDX_W + 1)'(k);
            if (cand >= c_REQ_N) begin
                cand = cand - c_REQ_N;
            end
            if (req[cand[c_IDX_W-1:0]]) begin
                pick = cand[c_IDX_W-1:0];
            end
        end
    end

    assign ptr_sum  = {1'b0, idx_q} + (c_IDX_W + 1)'(1);
    assign ptr_next = (ptr_sum >= c_REQ_N) ? '0 : ptr_sum[c_IDX_W-1:0];
    assign cur_mode = state_t'(mode[{idx_q, 1'b0} +: 2]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        phase_d = phase_q;
        led_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (|req) begin
                    state_d       = ARB_GRANT;
                    grant_d[pick] = 1'b1;
                    busy_d        = 1'b1;
                    idx_d         = pick;
                    slot_d        = '0;
                    phase_d       = 1'b1;
                end
            end
            ARB_GRANT: begin
                case (cur_mode)
                    STATE_ON:    led_d = 1'b1;
                    STATE_BLINK: led_d = phase_q;
                    default:     led_d = 1'b0;
                endcase
                if (!req[idx_q] || (tick && (slot_q == c_SLOT_LAST))) begin
                    state_d = ARB_GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else if (tick) begin
                    phase_d = ~phase_q;
                    slot_d  = slot_q + c_SLOT_W'(1);
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            slot_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_arbiter.sv
// ============================================================================
//  tb_led_arbiter : directed vectors plus multi-cycle sequences for led_arbiter
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_led_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'h0;
    logic [7:0] mode  = 8'h00;
    logic [3:0] grant;
    logic       busy;
    logic       led;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [7:0] mode;
        logic [3:0] grant;
        logic       busy;
        logic       led;
    } vec_t;

    vec_t vecs[$];

    led_arbiter #(
        .REQ_COUNT    (4),
        .SLOT_TICKS   (3),
        .TICK_DIVIDER (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .mode  (mode),
        .grant (grant),
        .busy  (busy),
        .led   (led)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [7:0] m,
                       input logic [3:0] g, input logic b, input logic l, input int n);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{rst: r, req: q, mode: m, grant: g, busy: b, led: l});
        end
    endtask

    task automatic start_seq(input logic [3:0] q, input logic [7:0] m);
        reset = 1'b1;
        req   = q;
        mode  = m;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] prev_g;
        logic       el;

        // Reset hold with all requesting, then first grant to requester 0
        add(1'b1, 4'hF, 8'hAA, 4'h0, 1'b0, 1'b0, 3);
        add(1'b0, 4'hF, 8'hAA, 4'h1, 1'b1, 1'b0, 1);
        // Reset over an active grant, then a blinking slot for requester 1
        add(1'b1, 4'h2, 8'h04, 4'h0, 1'b0, 1'b0, 1);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b0, 1);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b1, 4);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b0, 4);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b1, 3);
        add(1'b0, 4'h2, 8'h04, 4'h0, 1'b0, 1'b1, 1);
        add(1'b0, 4'h2, 8'h04, 4'h0, 1'b0, 1'b0, 1);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b0, 1);
        add(1'b0, 4'h2, 8'h04, 4'h2, 1'b1, 1'b1, 1);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            mode  = vecs[i].mode;
            cyc();
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].busy));
            chk($sformatf("vec%0d led", i),   32'(led),   32'(vecs[i].led));
        end

        // Two ON requesters alternate with a two-cycle gap between slots
        start_seq(4'b0101, 8'hAA);
        prev_g = 4'h0;
        for (int t = 0; t < 30; t++) begin
            cyc();
            if (t < 12)      eg = 4'b0001;
            else if (t < 14) eg = 4'b0000;
            else if (t < 26) eg = 4'b0100;
            else if (t < 28) eg = 4'b0000;
            else             eg = 4'b0001;
            chk($sformatf("rr t%0d grant", t), 32'(grant), 32'(eg));
            chk($sformatf("rr t%0d busy", t),  32'(busy),  32'(eg != 4'h0));
            chk($sformatf("rr t%0d led", t),   32'(led),   32'(prev_g != 4'h0));
            prev_g = eg;
        end

        // Granted requester drops its request mid-slot
        start_seq(4'b1001, 8'hAA);
        for (int t = 0; t < 5; t++) begin
            cyc();
            chk($sformatf("drop t%0d grant", t), 32'(grant), 32'h1);
        end
        req = 4'b1000;
        cyc();
        chk("drop gap grant", 32'(grant), 32'h0);
        chk("drop gap busy",  32'(busy),  32'h0);
        chk("drop gap led",   32'(led),   32'h1);
        cyc();
        chk("drop idle grant", 32'(grant), 32'h0);
        chk("drop idle led",   32'(led),   32'h0);
        cyc();
        chk("drop next grant", 32'(grant), 32'h8);
        chk("drop next busy",  32'(busy),  32'h1);

        // Reset during a grant with the pointer already advanced
        start_seq(4'b0110, 8'hAA);
        cyc();
        chk("rst g0", 32'(grant), 32'h2);
        cyc();
        req = 4'b0100;
        cyc();
        chk("rst exit grant", 32'(grant), 32'h0);
        cyc();
        chk("rst idle grant", 32'(grant), 32'h0);
        cyc();
        chk("rst g1 grant", 32'(grant), 32'h4);
        cyc();
        chk("rst g1 led", 32'(led), 32'h1);
        reset = 1'b1;
        cyc();
        chk("rst mid grant", 32'(grant), 32'h0);
        chk("rst mid led",   32'(led),   32'h0);
        chk("rst mid busy",  32'(busy),  32'h0);
        reset = 1'b0;
        req   = 4'b1111;
        cyc();
        chk("rst ptr grant", 32'(grant), 32'h1);

        // Mode 2'b11 reads as off; switch to ON mid-slot
        start_seq(4'b0001, 8'h03);
        for (int t = 0; t < 27; t++) begin
            if (t == 18) mode = 8'h02;
            cyc();
            if (t < 12)      eg = 4'b0001;
            else if (t < 14) eg = 4'b0000;
            else if (t < 26) eg = 4'b0001;
            else             eg = 4'b0000;
            el = (t >= 18) && (t <= 26);
            chk($sformatf("mode t%0d grant", t), 32'(grant), 32'(eg));
            chk($sformatf("mode t%0d led", t),   32'(led),   32'(el));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter REQ_COUNT, default 4: number of requesters sharing the LED.
REQ-002 Parameter SLOT_TICKS, default 10: maximum grant length, in ticks.
REQ-003 Parameter TICK_DIVIDER, default 5_000_000: clock cycles per tick (10 Hz at 50 MHz).
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 Port clock, input, 1 bit: 50 MHz system clock; all logic on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port req, input, REQ_COUNT bits: level request per requester.
REQ-008 Port mode, input, 2*REQ_COUNT bits: state_t per requester, slice [2i+1:2i] for requester i.
REQ-009 Port grant, output, REQ_COUNT bits: one-hot, or zero when no requester is granted.
REQ-010 Port busy, output, 1 bit: high while in ARB_GRANT.
REQ-011 Port led, output, 1 bit: shared LED drive.

Function
REQ-012 The FSM SHALL have three states, ARB_IDLE, ARB_GRANT and ARB_GAP, and all outputs SHALL be registered.
REQ-013 In ARB_IDLE with req nonzero, the FSM SHALL enter ARB_GRANT on the next edge and set grant to the first requester with req high, searching circularly from pointer ptr.
REQ-014 In ARB_IDLE with req zero, the FSM SHALL stay in ARB_IDLE with grant=0.
REQ-015 On entry to ARB_GRANT: slot counter cleared, tick counter cleared, blink phase set to 1.
REQ-016 Tick counter: counts cycles only in ARB_GRANT; tick pulses when count equals TICK_DIVIDER-1, then wraps to 0; width $clog2(TICK_DIVIDER).
REQ-017 On each tick in ARB_GRANT: blink phase toggles and slot counter increments; slot counter width $clog2(SLOT_TICKS).
REQ-018 ARB_GRANT SHALL exit to ARB_GAP when req[granted] is low, or when a tick occurs with slot counter equal to SLOT_TICKS-1; a dropped request takes priority if both occur in the same cycle.
REQ-019 On leaving ARB_GRANT: ptr set to (granted index + 1) mod REQ_COUNT, grant cleared.
REQ-020 ARB_GAP SHALL last exactly one cycle, with led=0 and grant=0, then go to ARB_IDLE.
REQ-021 led SHALL be registered from the current state, granted mode and phase, lagging grant by one cycle: STATE_OFF gives 0, STATE_ON gives 1, STATE_BLINK gives phase.
REQ-022 led SHALL be 0 in ARB_IDLE and ARB_GAP.
REQ-023 A mode encoding of 2'b11 SHALL be treated as STATE_OFF.
REQ-024 A mode change during a grant SHALL take effect on led one cycle later, with no effect on slot timing.
REQ-025 Requests from non-granted requesters SHALL never preempt an active grant.
REQ-026 A sole continuous requester SHALL be re-granted after ARB_GAP and ARB_IDLE, a 2-cycle gap.
REQ-027 An unreachable FSM state SHALL recover to ARB_IDLE on the next edge.

Reset
REQ-028 While reset is high at a rising edge: state ARB_IDLE, grant=0, busy=0, led=0, ptr=0, counters=0, phase=0.
REQ-029 Reset mid-grant SHALL drop grant and led on that same edge, with no ARB_GAP cycle.
REQ-030 After reset deasserts, requester 0 SHALL have the highest priority.

Structure
REQ-031 The shared package led_pkg SHALL hold state_t (STATE_OFF=0, STATE_BLINK=1, STATE_ON=2), arb_state_t and the default TICK_DIVIDER constant.
REQ-032 The tick counter SHALL be a sub-module tick_counter (clock, reset, enable, clear, tick) with synchronous active-high reset.
REQ-033 The remaining logic (FSM, pointer, slot counter, LED register) SHALL be in led_arbiter itself.

Verification (TICK_DIVIDER=4, SLOT_TICKS=3)
REQ-034 Reset held 3 cycles with req=4'b1111 -> grant=0, led=0, busy=0 throughout; after release, grant=4'b0001 on the first edge.
REQ-035 req=4'b0101 held, both modes ON -> grant 0001 for 12 cycles, 2-cycle gap, 0100 for 12 cycles, gap, 0001 again.
REQ-036 req=4'b0010, mode[3:2]=BLINK -> led=1 for 4 cycles, then 0 for 4, then 1 for 4 (one cycle after grant), then ARB_GAP.
REQ-037 req[0] dropped at cycle 5 of its grant while req=4'b1001 -> ARB_GAP next cycle, then grant=4'b1000.
REQ-038 Reset asserted mid-grant -> grant=0 and led=0 on that edge, ptr=0.
REQ-039 mode=2'b11 on the granted requester -> led=0 for the full slot; mode switched to ON mid-slot -> led=1 one cycle later, slot end unchanged.
